// File: rtl/rgb_pwm_pkg.sv
// Shared defaults and sizing helpers for the rgb_pwm block.
// Optional fading is compiled in with RGB_PWM_FADE_EN.
package rgb_pwm_pkg;

  localparam int DEF_CHANNELS = 3;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_PRESCALE = 1;

  // Last counter value before wrap: a period spans 2^width-1 counter steps.
  function automatic int cnt_max(input int width);
    return (1 << width) - 2;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty registers and the registered compare.
// RGB_PWM_FADE_EN makes active step by one toward shadow at each wrap.
module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_duty,
  input  logic             load,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm
);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (wr) shadow <= wr_duty;
      // load samples the pre-write shadow, so a colliding write waits a period
`ifdef RGB_PWM_FADE_EN
      if (load) begin
        if (active < shadow)      active <= active + 1'b1;
        else if (active > shadow) active <= active - 1'b1;
      end
`else
      if (load) active <= shadow;
`endif
      pwm <= (cnt < active);
    end
  end

endmodule

// File: rtl/rgb_pwm.sv
// Multi-channel PWM: shared prescaler and period counter, per-channel compare.
// Fading option: define RGB_PWM_FADE_EN.
module rgb_pwm
  import rgb_pwm_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [idx_width(CHANNELS)-1:0]    wr_chan,
  input  logic [WIDTH-1:0]                  wr_duty,
  output logic [CHANNELS-1:0]               pwm_out,
  output logic                              period_tick
);

  localparam int CW = idx_width(CHANNELS);
  localparam int PW = idx_width(PRESCALE);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(cnt_max(WIDTH));

  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] cnt;
  logic             step;
  logic             wrap;
  logic             new_period;

  assign step = (presc == PRE_LAST);
  assign wrap = step && (cnt == CNT_LAST);

  // period_tick is delayed twice so it lines up with the registered pwm_out of count 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      cnt         <= '0;
      new_period  <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      presc <= step ? '0 : presc + 1'b1;
      if (step) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      new_period  <= wrap;
      period_tick <= new_period;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (wr_en && (wr_chan == CW'(i))),
      .wr_duty (wr_duty),
      .load    (wrap),
      .cnt     (cnt),
      .pwm     (pwm_out[i])
    );
  end

endmodule

// File: doc/rgb_pwm.md
RGB_PWM -- requirements
Module: rgb_pwm

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of independent PWM outputs (1..8).
REQ-002 SHALL have parameter WIDTH, default 8: duty/counter width in bits (2..16).
REQ-003 SHALL have parameter PRESCALE, default 1: clk cycles per counter step (>=1).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port wr_en  input  1  write strobe, one write per cycle.
REQ-007 SHALL have port wr_chan  input  max(1,$clog2(CHANNELS))  target channel index.
REQ-008 SHALL have port wr_duty  input  WIDTH  new duty value.
REQ-009 SHALL have port pwm_out  output  CHANNELS  registered PWM outputs, one bit per channel.
REQ-010 SHALL have port period_tick  output  1  one-cycle pulse at each PWM period start.

Function
REQ-011 SHALL run a prescaler 0..PRESCALE-1; a step fires on the cycle it equals PRESCALE-1, then it wraps to 0.
REQ-012 SHALL advance the period counter by 1 per step, 0..2^WIDTH-2, then wrap to 0; period = (2^WIDTH-1)*PRESCALE clk cycles.
REQ-013 SHALL register pwm_out[i] = (counter < active[i]) one cycle after the counter value is presented.
REQ-014 SHALL hold pwm_out[i] constantly low for active[i]=0 and constantly high for active[i]=2^WIDTH-1.
REQ-015 SHALL store wr_duty into shadow[wr_chan] on the cycle wr_en is high; writes with wr_chan>=CHANNELS are ignored.
REQ-016 SHALL copy shadow into active for all channels on the step where the counter wraps to 0, so duty never changes mid-period.
REQ-017 SHALL, on a write coinciding with the wrap step, load active from the pre-write shadow; the new value takes effect one period later.
REQ-018 SHALL assert period_tick for exactly one clk cycle, aligned with the first pwm_out cycle of the new period.
REQ-019 SHALL let the last write win when one channel is written several times in a period.

Reset
REQ-020 SHALL, with rst_n low, force prescaler, counter, shadow, active, pwm_out and period_tick to 0 asynchronously.
REQ-021 SHALL, after rst_n deasserts, start with counter=0 and no period_tick until the first wrap.
REQ-022 SHALL discard any pending shadow write when reset asserts mid-period.

Configuration
REQ-023 SHALL use macro RGB_PWM_FADE_EN to compile in fading.
REQ-024 SHALL, with RGB_PWM_FADE_EN defined, move active[i] by exactly 1 toward shadow[i] at each wrap instead of copying; no change when equal.
REQ-025 SHALL, without RGB_PWM_FADE_EN, copy shadow to active directly (REQ-016); no fade logic present.

Structure
REQ-026 SHALL place the counter-max constant and the default parameter values in package rgb_pwm_pkg.
REQ-027 SHALL implement per-channel shadow/active/compare in sub-module pwm_channel, instantiated CHANNELS times; prescaler and counter shared in rgb_pwm.

Verification (CHANNELS=3, WIDTH=4, PRESCALE=2; period=30 clk)
REQ-028 SHALL check reset: rst_n low mid-period -> pwm_out=3'b000 and period_tick=0 immediately; first period_tick 30 clk after release.
REQ-029 SHALL check duty: write ch0=5, ch1=0, ch2=15 -> next period ch0 high 10 clk of 30, ch1 always low, ch2 always high.
REQ-030 SHALL check glitch-free update: write ch0=8 mid-period -> current period keeps old high time; 16 clk high from the next period_tick.
REQ-031 SHALL check wrap collision: write ch1=3 on the wrap step -> following period uses old value; the one after shows 6 clk high.
REQ-032 SHALL check invalid channel: wr_chan=3 with wr_duty=9 -> no channel changes.
REQ-033 SHALL check fade (RGB_PWM_FADE_EN): active ch0=2, write 5 -> high time 6, 8, 10 clk over the next three periods, then stays at 10.
